mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Shares the single-port 16-bit word memory (40 bytes, big-endian byte pairs at Addr/Addr+1, bytes 0–5 hard-wired program ROM) between two requesters.
  - The fetch port is read-only.
  - The data port handles load/store.
- Serialises requests into one-cycle memory accesses and registers the read data.
- Returns a one-cycle acknowledge per request.
- Rejects out-of-range and ROM-write accesses with an error flag instead of touching memory.

## Interface
- MEM_BYTES, 40, byte capacity of the attached memory; the highest legal word address is MEM_BYTES-2.
- ROM_BYTES, 6, lowest writable byte address; word writes with Addr < ROM_BYTES are illegal.
- Clk  in  1  single clock; all state changes on rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- FReq  in  1  fetch request, level; held until FAck.
- FAddr  in  16  fetch byte address.
- FAck  out  1  one-cycle fetch acknowledge.
- FData  out  16  fetched word; valid while FAck=1.
- FErr  out  1  fetch rejected; valid while FAck=1.
- DReq  in  1  data request, level; held until DAck.
- DWe  in  1  1=store, 0=load; stable while DReq=1.
- DAddr  in  16  data byte address.
- DWData  in  16  store data.
- DAck  out  1  one-cycle data acknowledge.
- DRData  out  16  load data; valid while DAck=1.
- DErr  out  1  data access rejected; valid while DAck=1.
- MemAddr  out  16  address to memory.
- MemInData  out  16  write data to memory.
- MemWrite  out  1  memory write strobe.
- MemRead  out  1  memory read strobe.
- MemOut  in  16  combinational memory read data.
- Busy  out  1  high in ACCESS and RESP.

## Operation
- FSM states:
  - IDLE: sample FReq/DReq. If either is set, select a winner, latch its address, write data, direction and legality into internal registers, and go to ACCESS. If neither is set, stay in IDLE.
  - ACCESS: drive MemAddr = latched address.
    - Legal store: MemWrite=1 and MemInData = latched data; memory commits at the closing edge.
    - Legal read: MemRead=1.
    - Illegal access: MemWrite=0 and MemRead=0.
    - At the closing edge, capture MemOut into the winner's read-data register (0 if illegal or store) and go to RESP.
  - RESP: assert the winner's Ack, plus Err if illegal, for exactly one cycle. Go to IDLE unconditionally. The requester drops Req at this edge, so a stale Req is never re-sampled.
- Fixed-priority arbitration (default): data wins over fetch when both are sampled high in IDLE.
- Legality:
  - Illegal if address > MEM_BYTES-2 (either port).
  - Illegal if a store has address < ROM_BYTES.
  - Odd addresses are legal; no alignment check.
- The comparison uses the full 16-bit address, unsigned.
- The memory bus is idle outside ACCESS: MemAddr=0, MemInData=0, strobes 0.
- FData and DRData hold their last value outside Ack cycles. The memory-bus strobes themselves are combinational decodes of state.

## Timing
- Reset values (async on ResetN=0):
  - State IDLE.
  - FAck, DAck, FErr, DErr, Busy, MemWrite and MemRead all 0.
  - FData, DRData, MemAddr and MemInData all 0.
  - Round-robin pointer set to "data preferred".
- Latency: request sampled at edge N → ACCESS in cycle N→N+1 → Ack high in cycle N+1→N+2. Throughput is one access per 3 cycles.
- A request rising while the arbiter is Busy waits and is sampled at the next IDLE edge.
- The losing requester keeps Req high and is served on the next pass.
- Reset mid-ACCESS: MemWrite drops immediately (async), so no partial write can be guaranteed or relied on. The aborted request gets no Ack; the requester must reissue.
- Req deasserting before Ack is a protocol violation; the latched request still completes and is acknowledged.

## Configuration
- MEMARB_RR_EN:
  - When defined, simultaneous requests are resolved round-robin. A 1-bit pointer records the last-served port, and the other port wins a tie. The pointer updates on every transition into ACCESS.
  - When undefined, fixed data-over-fetch priority applies and the pointer is not implemented.

## Test plan
- Fetch read: FReq, FAddr=0 → ACCESS with MemRead=1, then FAck=1 with FData=16'hDE01 (ROM contents) two edges after sampling, FErr=0.
- Store then load: DReq, DWe=1, DAddr=10, DWData=16'hA5C3 → DAck. Then a load from DAddr=10 → DRData=16'hA5C3. Also check that MemWrite was high for exactly one cycle.
- Simultaneous FReq (addr 2) and DReq (load addr 10):
  - Fixed priority: DAck comes first, FAck 3 cycles later.
  - With MEMARB_RR_EN: a repeated tie alternates winners.
- Illegal accesses each give Ack with Err=1, data 0, and no MemWrite/MemRead pulse:
  - Store to DAddr=4 (ROM).
  - Load from DAddr=39.
  - Fetch from FAddr=16'hFFFF.
- Reset: ResetN low during ACCESS of a store → MemWrite=0 immediately, no DAck. All outputs read their reset values, and the state returns to IDLE after ResetN goes high.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a fetch port (read-only) and a data port (load/store)
// are serialised into one-cycle accesses on a single 16-bit word memory.
// Params: MEM_BYTES (capacity), ROM_BYTES (first writable byte).
// Ports: Clk/ResetN; fetch FReq/FAddr -> FAck/FData/FErr;
//        data DReq/DWe/DAddr/DWData -> DAck/DRData/DErr;
//        memory bus MemAddr/MemInData/MemWrite/MemRead <- MemOut; Busy.
// Option: define MEMARB_RR_EN for round-robin tie breaking (default: data wins).
module mem_arbiter #(
    parameter int MEM_BYTES = 40,
    parameter int ROM_BYTES = 6
) (
    input  logic        Clk,
    input  logic        ResetN,
    input  logic        FReq,
    input  logic [15:0] FAddr,
    output logic        FAck,
    output logic [15:0] FData,
    output logic        FErr,
    input  logic        DReq,
    input  logic        DWe,
    input  logic [15:0] DAddr,
    input  logic [15:0] DWData,
    output logic        DAck,
    output logic [15:0] DRData,
    output logic        DErr,
    output logic [15:0] MemAddr,
    output logic [15:0] MemInData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [15:0] MemOut,
    output logic        Busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [15:0] MaxAddr = 16'(MEM_BYTES - 2);
    localparam logic [15:0] RomLim  = 16'(ROM_BYTES);

    state_t      state;
    state_t      stateNext;
    logic [15:0] latAddr;
    logic [15:0] latWData;
    logic        latWe;
    logic        latBad;
    logic        latData;
    logic        pickData;
    logic [15:0] selAddr;
    logic        selWe;
    logic        selBad;
    logic        anyReq;
    logic [15:0] rdWord;

    assign anyReq = FReq | DReq;

`ifdef MEMARB_RR_EN
    // Last-served port; reset value 0 (fetch) makes data win the first tie.
    logic lastData;

    always_comb pickData = DReq & (~FReq | ~lastData);

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            lastData <= 1'b0;
        end else if (state == IDLE && anyReq) begin
            lastData <= pickData;
        end
    end
`else
    always_comb pickData = DReq;
`endif

    always_comb begin
        selAddr = pickData ? DAddr : FAddr;
        selWe   = pickData & DWe;
        selBad  = (selAddr > MaxAddr) | (selWe & (selAddr < RomLim));
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (anyReq) stateNext = ACCESS;
            ACCESS:  stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Bus and handshake outputs are pure decodes of state and the latch.
    always_comb begin
        MemAddr   = 16'h0;
        MemInData = 16'h0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        FAck      = 1'b0;
        FErr      = 1'b0;
        DAck      = 1'b0;
        DErr      = 1'b0;
        Busy      = (state != IDLE);
        if (state == ACCESS) begin
            MemAddr  = latAddr;
            MemWrite = ~latBad & latWe;
            MemRead  = ~latBad & ~latWe;
            if (MemWrite) MemInData = latWData;
        end
        if (state == RESP) begin
            DAck = latData;
            DErr = latData & latBad;
            FAck = ~latData;
            FErr = ~latData & latBad;
        end
    end

    assign rdWord = (latBad | latWe) ? 16'h0 : MemOut;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            latAddr  <= 16'h0;
            latWData <= 16'h0;
            latWe    <= 1'b0;
            latBad   <= 1'b0;
            latData  <= 1'b0;
            FData    <= 16'h0;
            DRData   <= 16'h0;
        end else begin
            if (state == IDLE && anyReq) begin
                latAddr  <= selAddr;
                latWData <= DWData;
                latWe    <= selWe;
                latBad   <= selBad;
                latData  <= pickData;
            end
            if (state == ACCESS) begin
                if (latData) DRData <= rdWord;
                else         FData  <= rdWord;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte-array memory model on the bus,
// shadow-memory reference model, directed cases then random traffic.
module tb_mem_arbiter;

    logic        Clk = 1'b0;
    logic        ResetN;
    logic        FReq;
    logic [15:0] FAddr;
    logic        FAck;
    logic [15:0] FData;
    logic        FErr;
    logic        DReq;
    logic        DWe;
    logic [15:0] DAddr;
    logic [15:0] DWData;
    logic        DAck;
    logic [15:0] DRData;
    logic        DErr;
    logic [15:0] MemAddr;
    logic [15:0] MemInData;
    logic        MemWrite;
    logic        MemRead;
    logic [15:0] MemOut;
    logic        Busy;

    int checks = 0;
    int failures = 0;

    mem_arbiter dut (
        .Clk(Clk), .ResetN(ResetN),
        .FReq(FReq), .FAddr(FAddr), .FAck(FAck), .FData(FData), .FErr(FErr),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
        .DAck(DAck), .DRData(DRData), .DErr(DErr),
        .MemAddr(MemAddr), .MemInData(MemInData),
        .MemWrite(MemWrite), .MemRead(MemRead),
        .MemOut(MemOut), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // Attached memory: 40 bytes, big-endian words, bytes 0..5 read-only.
    logic [7:0] mem [0:39];
    logic [7:0] initVal [0:39];
    logic [7:0] shadow [0:39];
    bit memLoad = 1'b1;

    always @(posedge Clk) begin
        int ia;
        ia = int'(MemAddr);
        if (memLoad) begin
            for (int i = 0; i < 40; i++) mem[i] <= initVal[i];
        end else if (MemWrite && ia >= 6 && ia <= 38) begin
            mem[ia]     <= MemInData[15:8];
            mem[ia + 1] <= MemInData[7:0];
        end
    end

    always_comb begin
        MemOut = 16'h0;
        if (MemAddr <= 16'd38)
            MemOut = {mem[int'(MemAddr)], mem[int'(MemAddr) + 1]};
    end

    // Reference model state: shadow memory and last served port.
    bit lastD = 1'b0;

    function automatic logic [16:0] refAccess(bit we, logic [15:0] a,
                                              logic [15:0] wd);
        int ia;
        ia = int'(a);
        if (a > 16'd38 || (we && a < 16'd6)) return {1'b1, 16'h0};
        if (we) begin
            shadow[ia]     = wd[15:8];
            shadow[ia + 1] = wd[7:0];
            return 17'h0;
        end
        return {1'b0, shadow[ia], shadow[ia + 1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkIdleBus(input string tag);
        chk({tag, ".MemAddr"}, 32'(MemAddr), 0);
        chk({tag, ".MemInData"}, 32'(MemInData), 0);
        chk({tag, ".strobes"}, {30'h0, MemWrite, MemRead}, 0);
        chk({tag, ".acks"}, {28'h0, FAck, FErr, DAck, DErr}, 0);
        chk({tag, ".Busy"}, 32'(Busy), 0);
    endtask

    // One round: optional fetch and/or data request raised together.
    task automatic serve(input string tag, input bit f, input bit d,
                         input logic [15:0] fa, input bit we,
                         input logic [15:0] da, input logic [15:0] wd);
        bit prefD, dFirst, ill;
        logic [16:0] rf, rdr;
        int eFCyc, eDCyc, eWr, eRd, fCyc, dCyc, wr, rd;
        logic [15:0] a1, a2;
`ifdef MEMARB_RR_EN
        prefD = !lastD;
`else
        prefD = 1'b1;
`endif
        dFirst = d && (!f || prefD);
        eFCyc = -1; eDCyc = -1; eWr = 0; eRd = 0;
        rf = 17'h0; rdr = 17'h0;
        a1 = dFirst ? da : fa;
        a2 = dFirst ? fa : da;
        if (dFirst) begin
            rdr = refAccess(we, da, wd);
            eDCyc = 2;
            if (f) begin rf = refAccess(1'b0, fa, 16'h0); eFCyc = 5; end
        end else begin
            rf = refAccess(1'b0, fa, 16'h0);
            eFCyc = 2;
            if (d) begin rdr = refAccess(we, da, wd); eDCyc = 5; end
        end
        if (f) begin
            ill = rf[16];
            if (!ill) eRd++;
        end
        if (d) begin
            ill = rdr[16];
            if (!ill && we) eWr++;
            if (!ill && !we) eRd++;
        end
        lastD = (f && d) ? !dFirst : d;
        @(negedge Clk);
        FReq = f; FAddr = fa;
        DReq = d; DWe = we; DAddr = da; DWData = wd;
        fCyc = -1; dCyc = -1; wr = 0; rd = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clk);
            if (MemWrite) wr++;
            if (MemRead) rd++;
            if (c == 1) begin
                chk({tag, ".addr1"}, 32'(MemAddr), 32'(a1));
                chk({tag, ".busy1"}, 32'(Busy), 1);
            end
            if (c == 4 && f && d)
                chk({tag, ".addr2"}, 32'(MemAddr), 32'(a2));
            if (FAck) begin
                if (fCyc < 0) begin
                    fCyc = c;
                    chk({tag, ".FData"}, 32'(FData), 32'(rf[15:0]));
                    chk({tag, ".FErr"}, 32'(FErr), 32'(rf[16]));
                end
                FReq = 1'b0;
            end
            if (DAck) begin
                if (dCyc < 0) begin
                    dCyc = c;
                    chk({tag, ".DRData"}, 32'(DRData), 32'(rdr[15:0]));
                    chk({tag, ".DErr"}, 32'(DErr), 32'(rdr[16]));
                end
                DReq = 1'b0;
            end
        end
        FReq = 1'b0; DReq = 1'b0;
        chk({tag, ".fAckCycle"}, 32'(fCyc), 32'(eFCyc));
        chk({tag, ".dAckCycle"}, 32'(dCyc), 32'(eDCyc));
        chk({tag, ".writeCycles"}, 32'(wr), 32'(eWr));
        chk({tag, ".readCycles"}, 32'(rd), 32'(eRd));
        if (f) chk({tag, ".FDataHold"}, 32'(FData), 32'(rf[15:0]));
        if (d) chk({tag, ".DRDataHold"}, 32'(DRData), 32'(rdr[15:0]));
    endtask

    initial begin
        int dSeen;
        initVal[0] = 8'hDE; initVal[1] = 8'h01; initVal[2] = 8'h12;
        initVal[3] = 8'h34; initVal[4] = 8'h56; initVal[5] = 8'h78;
        for (int i = 6; i < 40; i++) initVal[i] = 8'($urandom);
        for (int i = 0; i < 40; i++) shadow[i] = initVal[i];
        ResetN = 1'b0;
        FReq = 0; FAddr = 0; DReq = 0; DWe = 0; DAddr = 0; DWData = 0;
        #2;
        chkIdleBus("reset");
        chk("reset.FData", 32'(FData), 0);
        chk("reset.DRData", 32'(DRData), 0);
        @(negedge Clk);
        @(negedge Clk);
        memLoad = 1'b0;
        ResetN = 1'b1;

        serve("fetchRom", 1, 0, 16'd0, 0, 16'd0, 16'h0);
        chk("fetchRom.word", 32'(FData), 32'h0000DE01);
        serve("store10", 0, 1, 16'd0, 1, 16'd10, 16'hA5C3);
        serve("load10", 0, 1, 16'd0, 0, 16'd10, 16'h0);
        chk("load10.word", 32'(DRData), 32'h0000A5C3);
        serve("tie1", 1, 1, 16'd2, 0, 16'd10, 16'h0);
        serve("tie2", 1, 1, 16'd2, 0, 16'd10, 16'h0);
        serve("romStore", 0, 1, 16'd0, 1, 16'd4, 16'h1234);
        serve("load39", 0, 1, 16'd0, 0, 16'd39, 16'h0);
        serve("fetchFFFF", 1, 0, 16'hFFFF, 0, 16'd0, 16'h0);
        serve("load38", 0, 1, 16'd0, 0, 16'd38, 16'h0);
        serve("store6", 0, 1, 16'd0, 1, 16'd6, 16'h5A5A);
        serve("fetch7odd", 1, 0, 16'd7, 0, 16'd0, 16'h0);

        // Reset in the middle of a store access.
        @(negedge Clk);
        DReq = 1; DWe = 1; DAddr = 16'd12; DWData = 16'hBEEF;
        @(negedge Clk);
        chk("rst.preWrite", 32'(MemWrite), 1);
        #2 ResetN = 1'b0;
        #1;
        chkIdleBus("rst");
        chk("rst.FData", 32'(FData), 0);
        chk("rst.DRData", 32'(DRData), 0);
        DReq = 1'b0;
        lastD = 1'b0;
        @(negedge Clk);
        ResetN = 1'b1;
        dSeen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            if (DAck) dSeen++;
        end
        chk("rst.noAck", 32'(dSeen), 0);
        chk("rst.idle", 32'(Busy), 0);
        serve("rst.reissue", 0, 1, 16'd0, 1, 16'd12, 16'hBEEF);
        serve("rst.tie", 1, 1, 16'd2, 0, 16'd12, 16'h0);

        for (int n = 0; n < 40; n++) begin
            bit f, d, we;
            logic [15:0] fa, da;
            int r;
            f = 1'($urandom);
            d = 1'($urandom);
            if (!f && !d) f = 1'b1;
            we = 1'($urandom);
            r = int'($urandom_range(0, 9));
            fa = (r == 0) ? 16'hFFFF : 16'($urandom_range(0, 41));
            r = int'($urandom_range(0, 9));
            da = (r == 0) ? 16'($urandom_range(39, 65535))
                          : 16'($urandom_range(0, 38));
            serve("rand", f, d, fa, we, da, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
